// File: rtl/phy_pkg.sv
// Symbols and state encoding shared by the PHY serializer and the serial-to-parallel receiver.
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_SYM  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_SYM = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;
endpackage

// File: rtl/tx_shifter.sv
// Byte load/shift register with a free-running bit counter; loads on boundary (bit_cnt==7), shifts MSB-first otherwise.
module tx_shifter
  import phy_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [BYTE_W-1:0] i_load_dat,
  output logic              o_boundary,
  output logic              o_ser
);

  logic [BYTE_W-1:0] r_shift;
  logic [2:0]        r_bit_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit_cnt <= 3'd7;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (o_boundary) begin
        r_shift <= i_load_dat;
      end else begin
        r_shift <= {r_shift[BYTE_W-2:0], 1'b0};
      end
    end
  end

  assign o_boundary = (r_bit_cnt == 3'd7);
  assign o_ser      = r_shift[BYTE_W-1];

endmodule

// File: rtl/partoserial_tx.sv
// PHY transmit serializer: COM training burst after reset/resync, then payload bytes or IDLE fill, MSB first.
module partoserial_tx
  import phy_pkg::*;
#(
  parameter int                SYNC_COUNT = 8,
  parameter logic [BYTE_W-1:0] COM_SYM    = phy_pkg::COM_SYM,
  parameter logic [BYTE_W-1:0] IDLE_SYM   = phy_pkg::IDLE_SYM
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              resync,
  output logic              ready,
  output logic              data_out,
  output logic              active
);

  state_e            r_state;
  logic [3:0]        r_sync_cnt;
  logic              r_resync_pend;
  logic              r_active;

  state_e            w_state_nxt;
  logic [3:0]        w_sync_cnt_nxt;
  logic [3:0]        w_cnt_inc;
  logic              w_pend_nxt;
  logic              w_resync_hit;
  logic              w_boundary;
  logic [BYTE_W-1:0] w_load_dat;

  tx_shifter u_shifter (
    .i_clk      (clk_32f),
    .i_reset    (reset),
    .i_load_dat (w_load_dat),
    .o_boundary (w_boundary),
    .o_ser      (data_out)
  );

  assign w_resync_hit = resync | r_resync_pend;

  always_comb begin
    w_state_nxt    = r_state;
    w_sync_cnt_nxt = r_sync_cnt;
    w_pend_nxt     = r_resync_pend;
    w_cnt_inc      = '0;
    w_load_dat     = IDLE_SYM;
    if (w_boundary) begin
      w_pend_nxt = 1'b0;
      if (w_resync_hit || (r_state == ST_SYNC)) begin
        // A resync counts its own COM as the first of a fresh burst.
        w_load_dat = COM_SYM;
        w_cnt_inc  = w_resync_hit ? 4'd1 : r_sync_cnt + 4'd1;
        if (w_cnt_inc == 4'(SYNC_COUNT)) begin
          w_state_nxt    = ST_ACTIVE;
          w_sync_cnt_nxt = '0;
        end else begin
          w_state_nxt    = ST_SYNC;
          w_sync_cnt_nxt = w_cnt_inc;
        end
      end else if (valid_in) begin
        w_load_dat = data_in;
      end
    end else begin
      w_pend_nxt = r_resync_pend | resync;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state       <= ST_SYNC;
      r_sync_cnt    <= '0;
      r_resync_pend <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sync_cnt    <= w_sync_cnt_nxt;
      r_resync_pend <= w_pend_nxt;
      r_active      <= (w_state_nxt == ST_ACTIVE);
    end
  end

  assign ready  = (r_state == ST_ACTIVE) && w_boundary && !w_resync_hit;
  assign active = r_active;

endmodule

// File: tb/tb_partoserial_tx.sv
// Bench for partoserial_tx: byte-level directed table, reset-mid-byte sequence, and randomized run against a reference model.
module tb_partoserial_tx;
  localparam int         SC   = 8;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       resync;
  logic       ready;
  logic       data_out;
  logic       active;

  int checks   = 0;
  int failures = 0;

  partoserial_tx #(.SYNC_COUNT(SC)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .resync   (resync),
    .ready    (ready),
    .data_out (data_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model: tracks position within the byte slot, training progress
  // and a latched resync request, and the byte currently on the wire.
  int         m_phase;
  bit         m_train;
  int         m_coms;
  bit         m_pend;
  logic [7:0] m_sh;

  function automatic logic m_ready();
    return !m_train && (m_phase == 0) && !resync && !m_pend;
  endfunction

  task automatic model_edge();
    logic [7:0] b;
    if (reset) begin
      m_phase = 0; m_train = 1; m_coms = 0; m_pend = 0; m_sh = 8'h00;
    end else begin
      if (m_phase == 0) begin
        if (resync || m_pend) begin
          b = COM; m_coms = 1; m_pend = 0; m_train = (m_coms < SC);
        end else if (m_train) begin
          b = COM; m_coms++;
          if (m_coms >= SC) m_train = 0;
        end else begin
          b = valid_in ? data_in : IDLE;
        end
        m_sh = b;
      end else begin
        if (resync) m_pend = 1;
        m_sh = m_sh << 1;
      end
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("ready", 32'(ready), 32'(m_ready()));
    chk("active", 32'(active), 32'(!m_train));
    @(posedge clk_32f);
    model_edge();
    @(negedge clk_32f);
    chk("data_out", 32'(data_out), 32'(m_sh[7]));
  endtask

  task automatic send_byte(input logic v, input logic [7:0] d, input int rs_at,
                           output logic [7:0] got, output logic rdy0);
    got  = 8'h00;
    rdy0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      valid_in = v;
      data_in  = d;
      resync   = (k == rs_at);
      #1;
      if (k == 0) rdy0 = ready;
      step();
      got = {got[6:0], data_out};
    end
    resync = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         rs_at;
    logic [7:0] exp_byte;
    logic       exp_rdy;
    logic       exp_act;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] got;
    logic       rdy0;
    vec_t       r;

    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00; resync = 1'b0;
    @(posedge clk_32f);
    model_edge();
    @(negedge clk_32f);

    // Reset held, data_out must stay low.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_dout", 32'(data_out), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < SC; i++)
      vecs.push_back('{1'b0, 8'h00, -1, COM, 1'b0, (i == SC - 1)});
    vecs.push_back('{1'b0, 8'h00, -1, IDLE,  1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'hA5, -1, 8'hA5, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'hA5, -1, 8'hA5, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'hA5,  3, 8'hA5, 1'b1, 1'b1});
    for (int i = 0; i < SC; i++)
      vecs.push_back('{1'b1, 8'hA5, -1, COM, 1'b0, (i == SC - 1)});
    vecs.push_back('{1'b1, 8'hA5, -1, 8'hA5, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, -1, IDLE,  1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'hBC, -1, 8'hBC, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'h7C, -1, 8'h7C, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, -1, IDLE,  1'b1, 1'b1});

    foreach (vecs[i]) begin
      r = vecs[i];
      send_byte(r.v, r.d, r.rs_at, got, rdy0);
      chk($sformatf("vec%0d_byte", i), 32'(got), 32'(r.exp_byte));
      chk($sformatf("vec%0d_rdy", i), 32'(rdy0), 32'(r.exp_rdy));
      chk($sformatf("vec%0d_act", i), 32'(active), 32'(r.exp_act));
    end

    // Reset at bit 3 of a payload byte, then the full burst restarts.
    valid_in = 1'b1; data_in = 8'hFF;
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1;
    step();
    chk("midbyte_rst_dout", 32'(data_out), 32'd0);
    chk("midbyte_rst_act", 32'(active), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < SC; i++) begin
      send_byte(1'b1, 8'hFF, -1, got, rdy0);
      chk($sformatf("retrain%0d_byte", i), 32'(got), 32'(COM));
      chk($sformatf("retrain%0d_rdy", i), 32'(rdy0), 32'd0);
    end
    chk("retrain_act", 32'(active), 32'd1);
    send_byte(1'b1, 8'hFF, -1, got, rdy0);
    chk("post_retrain_byte", 32'(got), 32'hFF);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 599) == 0);
      resync   = ($urandom_range(0, 49) == 0);
      valid_in = $urandom_range(0, 1);
      data_in  = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/partoserial_tx.md
Name: partoserial_tx

Overview:
- PHY transmit serializer; sits directly upstream of the serial-to-parallel receiver and drives its serial input.
- Accepts 8-bit bytes from the link layer and shifts them out MSB-first, one bit per clk_32f cycle.
- After reset or a resync request, sends a training burst of COM symbols (8'hBC). In ACTIVE it sends payload bytes, and fills empty byte slots with IDLE symbols (8'h7C) so the receiver can lock and detect idle.

Parameters:
SYNC_COUNT, 8, number of COM bytes sent per training burst (legal 1..15)
COM_SYM, 8'hBC, comma/training symbol
IDLE_SYM, 8'h7C, idle fill symbol

Ports:
clk_32f  input  1  bit clock; one serial bit per rising edge
reset    input  1  synchronous, active-high reset
data_in  input  8  parallel payload byte
valid_in input  1  data_in holds a byte to send
resync   input  1  request a new training burst; single-cycle pulse or level
ready    output 1  high on byte-boundary cycles in ACTIVE when a byte may be taken
data_out output 1  serial bit stream, MSB first
active   output 1  high while in ACTIVE state (training complete)

Behaviour:
- One clock domain only. All state updates on the rising edge of clk_32f. Reset sampled on that edge.
- Reset (dominates all inputs, including mid-byte):
  - shift_q=0, hence data_out=0
  - bit_cnt=7, state=SYNC, sync_cnt=0, resync_pend=0
  - active=0, ready=0
- Boundary cycle: bit_cnt==7. The first cycle after reset deasserts is a boundary.
- bit_cnt: 3-bit, increments every cycle, wraps 7->0.
- Byte timing:
  - On a boundary edge, a new byte is loaded into shift_q.
  - On all other edges, shift_q shifts left by one, filling LSB with 0.
  - data_out = shift_q[7], registered.
  - Latency: the byte loaded at edge E shows its MSB right after E and its LSB after E+7. Back-to-back bytes have no gaps.
- State SYNC:
  - Each boundary loads COM_SYM and increments sync_cnt.
  - On the boundary that loads the SYNC_COUNT-th COM, state goes to ACTIVE and sync_cnt clears.
  - ready=0 throughout.
- State ACTIVE:
  - ready = boundary && !resync && !resync_pend (combinational).
  - Boundary with ready && valid_in: load data_in. The handshake completes on this edge.
  - Boundary with ready && !valid_in: load IDLE_SYM.
  - valid_in outside a boundary is ignored; the source holds data_in and valid_in until ready.
- Resync:
  - resync asserted in ACTIVE on a non-boundary cycle sets resync_pend.
  - At the next boundary, if resync or resync_pend is set: load COM_SYM, set state=SYNC, sync_cnt=1, clear resync_pend. The burst still totals SYNC_COUNT COMs.
  - resync at a boundary wins over valid_in. ready is 0 that cycle, so no byte is lost or duplicated.
  - resync during SYNC restarts the burst: at the next boundary sync_cnt=1.
- Payload bytes equal to COM_SYM or IDLE_SYM are sent unchanged. Avoiding them is the link layer's job.
- active = (state==ACTIVE), registered.

Decomposition:
- Shared package phy_pkg holds:
  - COM_SYM and IDLE_SYM constants, shared with the receiver
  - state encoding: SYNC=1'b0, ACTIVE=1'b1
  - BYTE_W=8
- One natural sub-module, tx_shifter: 8-bit load/shift register plus 3-bit bit_cnt, with a boundary output. The FSM, sync counter, resync latch and handshake stay in the top level.

Test Plan:
1. Reset held 3 cycles, then released with valid_in=0 -> data_out=0 during reset. Then 8 COM bytes (10111100 repeated) over 64 cycles. active rises right after the edge that loads the 8th COM. Next byte is 01111100 (IDLE).
2. After training, hold data_in=8'hA5 with valid_in=1 -> ready pulses once per 8 cycles. Each handshake serializes 10100101 MSB first with no gaps between bytes. valid_in low -> IDLE bytes.
3. Pulse resync for 1 cycle mid-byte while valid_in=1 -> current byte completes. Next boundary shows ready=0 and loads COM. 8 COMs are sent in total, then ready returns and the pending 8'hA5 is sent exactly once.
4. Assert reset at bit 3 of a payload byte -> data_out=0 on the next cycle. The full training burst restarts 1 cycle after release.
5. Drive data_in=8'hBC and 8'h7C as payload -> both sent verbatim. active stays 1.
6. Loop data_out into the serial-to-parallel receiver -> receiver idle-detect asserts after the burst plus the first IDLE byte. It deasserts during resync COMs.
